// File: rtl/filter_pkg.sv
// filter_pkg: FSM state encodings, a constant clog2 and saturation-bound helpers
// shared by the filter stages.
package filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEAR  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic longint sat_hi(input int width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/sat_signed.sv
// sat_signed: combinational clamp of a signed IN_W-bit value to signed OUT_W bits.
module sat_signed
  import filter_pkg::*;
#(
  parameter int IN_W  = 29,
  parameter int OUT_W = 28
)(
  input  logic [IN_W-1:0]  i_value,
  output logic [OUT_W-1:0] o_value
);

  if (OUT_W >= IN_W) begin : g_pass
    assign o_value = OUT_W'($signed(i_value));
  end else begin : g_clamp
    localparam logic [OUT_W-1:0] HI = OUT_W'(sat_hi(OUT_W));
    localparam logic [OUT_W-1:0] LO = OUT_W'(sat_lo(OUT_W));
    logic [IN_W-OUT_W:0] w_top;

    // Value fits only when the bits above the output sign are all copies of it.
    assign w_top = i_value[IN_W-1:OUT_W-1];

    always_comb begin
      o_value = i_value[OUT_W-1:0];
      if (!(&w_top) && (|w_top)) o_value = i_value[IN_W-1] ? LO : HI;
    end
  end

endmodule

// File: rtl/hp_filter_stage_signed.sv
// hp_filter_stage_signed: signed first-order DC-removal stage (OUT = IN - running DC estimate).
// Define HP_FILTER_GEARSHIFT_EN to enable the startup gear-shift settling FSM.
module hp_filter_stage_signed
  import filter_pkg::*;
#(
  parameter int IN_DATA_BITS  = 28,
  parameter int SHIFT_BITS    = 6,
  parameter int OUT_DATA_BITS = 28,
  parameter int GEAR_SAMPLES  = 16
)(
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     CE,
  input  logic                     RESTART,
  input  logic [IN_DATA_BITS-1:0]  IN_VALUE,
  output logic [OUT_DATA_BITS-1:0] OUT_VALUE,
  output logic                     OUT_VALID,
  output logic                     SETTLED
);

  localparam int ACC_W  = IN_DATA_BITS + SHIFT_BITS;
  localparam int DIFF_W = IN_DATA_BITS + 1;

  if (SHIFT_BITS < 2) begin : g_chk_shift
    $error("SHIFT_BITS must be >= 2");
  end
  if (GEAR_SAMPLES < 1) begin : g_chk_gear
    $error("GEAR_SAMPLES must be >= 1");
  end
  if (OUT_DATA_BITS < 2 || OUT_DATA_BITS > IN_DATA_BITS + 1) begin : g_chk_out
    $error("OUT_DATA_BITS out of range");
  end

  state_t                    r_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic [OUT_DATA_BITS-1:0]  r_out;
  logic                      r_vld;
  logic                      r_settled;

  logic signed [IN_DATA_BITS-1:0] w_est;
  logic signed [DIFF_W-1:0]       w_diff;
  logic signed [ACC_W-1:0]        w_step;
  logic signed [ACC_W-1:0]        w_acc_upd;
  logic signed [ACC_W-1:0]        w_preload;
  logic [OUT_DATA_BITS-1:0]       w_sat;

  // acc holds the DC estimate scaled by 2^SHIFT_BITS; its fraction bits carry rounding history.
  assign w_est     = r_acc[ACC_W-1:SHIFT_BITS];
  assign w_diff    = DIFF_W'($signed(IN_VALUE)) - DIFF_W'(w_est);
  assign w_preload = {IN_VALUE, {SHIFT_BITS{1'b0}}};
  assign w_acc_upd = r_acc + w_step;

`ifdef HP_FILTER_GEARSHIFT_EN
  localparam int CS_W = clog2(SHIFT_BITS + 1);
  localparam int GC_W = (GEAR_SAMPLES > 1) ? clog2(GEAR_SAMPLES) : 1;

  logic [CS_W-1:0] r_cur_shift;
  logic [GC_W-1:0] r_gear_cnt;
  logic [CS_W-1:0] w_next_shift;

  assign w_next_shift = r_cur_shift + CS_W'(1);
  // Smaller cur_shift means a larger step: est moves by diff * 2^-cur_shift.
  assign w_step = ACC_W'(w_diff) <<< (CS_W'(SHIFT_BITS) - r_cur_shift);
`else
  assign w_step = ACC_W'(w_diff);
`endif

  sat_signed #(
    .IN_W  (DIFF_W),
    .OUT_W (OUT_DATA_BITS)
  ) u_sat (
    .i_value (w_diff),
    .o_value (w_sat)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_acc       <= '0;
      r_state     <= ST_IDLE;
      r_out       <= '0;
      r_vld       <= 1'b0;
      r_settled   <= 1'b0;
`ifdef HP_FILTER_GEARSHIFT_EN
      r_cur_shift <= '0;
      r_gear_cnt  <= '0;
`endif
    end else begin
      r_vld <= CE;
      if (CE) begin
        if (RESTART || r_state == ST_IDLE) begin
          // Preload: est jumps straight to the input so settling starts from the signal level.
          r_acc <= w_preload;
          r_out <= '0;
`ifdef HP_FILTER_GEARSHIFT_EN
          r_cur_shift <= CS_W'(1);
          r_gear_cnt  <= '0;
          r_state     <= ST_GEAR;
          r_settled   <= 1'b0;
`else
          r_state     <= ST_TRACK;
          r_settled   <= 1'b1;
`endif
        end else begin
          r_acc <= w_acc_upd;
          r_out <= w_sat;
`ifdef HP_FILTER_GEARSHIFT_EN
          if (r_state == ST_GEAR) begin
            if (r_gear_cnt == GC_W'(GEAR_SAMPLES - 1)) begin
              r_gear_cnt  <= '0;
              r_cur_shift <= w_next_shift;
              if (w_next_shift == CS_W'(SHIFT_BITS)) begin
                r_state   <= ST_TRACK;
                r_settled <= 1'b1;
              end
            end else begin
              r_gear_cnt <= r_gear_cnt + GC_W'(1);
            end
          end
`endif
        end
      end
    end
  end

  assign OUT_VALUE = r_out;
  assign OUT_VALID = r_vld;
  assign SETTLED   = r_settled;

endmodule
